shift_rows_pipe: RTL and testbench

Parametrised, registered ShiftRows/InvShiftRows stage for Rijndael states of NB columns (NB = 4, 6 or 8). Each beat's `in_mode` selects forward or inverse permutation. Beats move through a valid/ready handshake with a one-cycle output register and a one-entry skid buffer, so the stage runs at full throughput under backpressure. The stage sits between SubBytes and MixColumns in pipelined AES/Rijndael round datapaths and keeps a wrapping count of delivered blocks.

---
 rtl/shift_rows_pipe.sv | 116 +++++++++++
 tb/tb_shift_rows_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows stage for Rijndael states of NB columns,
// with a valid/ready handshake, a one-entry skid buffer and a wrapping block counter.
module shift_rows_pipe #(
    parameter int unsigned NB    = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              out_mode,
    output logic [CNT_W-1:0]  blk_cnt
);

    localparam int unsigned W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : gen_bad_nb
        $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0] fwd;
    logic [W-1:0] inv;
    logic [W-1:0] perm;

    // Pure byte wiring: each output byte picks a fixed source byte per mode.
    for (genvar c = 0; c < NB; c++) begin : gen_col
        for (genvar r = 0; r < 4; r++) begin : gen_row
            localparam int unsigned S  = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int unsigned CF = (c + S) % NB;
            localparam int unsigned CI = (c + NB - S) % NB;
            assign fwd[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*CF+r) -: 8];
            assign inv[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*CI+r) -: 8];
        end
    end

    assign perm = in_mode ? inv : fwd;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_mode_q, out_mode_d;
    logic             skid_valid_q, skid_valid_d;
    logic [W-1:0]     skid_data_q, skid_data_d;
    logic             skid_mode_q, skid_mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic drain;

    assign in_ready  = ~skid_valid_q & ~flush;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign blk_cnt   = cnt_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mode_d   = out_mode_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_mode_d  = skid_mode_q;
        cnt_d        = drain ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            // A full skid implies in_ready=0, so no accept competes with the refill.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_mode_d   = skid_mode_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = perm;
                    out_mode_d = in_mode;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm;
            skid_mode_d  = in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mode_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_mode_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mode_q   <= out_mode_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_mode_q  <= skid_mode_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed and randomised checks of shift_rows_pipe for NB = 4, 6 and 8.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         flush4, iv4, ir4, im4, ov4, or4, om4;
    logic [127:0] id4, od4;
    logic [3:0]   cnt4;
    logic         flush6, iv6, ir6, im6, ov6, or6, om6;
    logic [191:0] id6, od6;
    logic [15:0]  cnt6;
    logic         flush8, iv8, ir8, im8, ov8, or8, om8;
    logic [255:0] id8, od8;
    logic [15:0]  cnt8;

    shift_rows_pipe #(.NB(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4), .in_valid(iv4), .in_ready(ir4),
        .in_data(id4), .in_mode(im4), .out_valid(ov4), .out_ready(or4),
        .out_data(od4), .out_mode(om4), .blk_cnt(cnt4)
    );
    shift_rows_pipe #(.NB(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .flush(flush6), .in_valid(iv6), .in_ready(ir6),
        .in_data(id6), .in_mode(im6), .out_valid(ov6), .out_ready(or6),
        .out_data(od6), .out_mode(om6), .blk_cnt(cnt6)
    );
    shift_rows_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(iv8), .in_ready(ir8),
        .in_data(id8), .in_mode(im8), .out_valid(ov8), .out_ready(or8),
        .out_data(od8), .out_mode(om8), .blk_cnt(cnt8)
    );

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] IDX4     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IDX4_FWD = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [191:0] IDX6     =
        192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] IDX6_FWD =
        192'h00050a0f04090e13080d12170c11160310150207_1401060b;
    localparam logic [255:0] IDX8     =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] IDX8_FWD =
        256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

    int total = 0;
    int bad   = 0;

    // Reference NB=4 permutation built straight from the row-shift definition.
    function automatic logic [127:0] ref4(input logic [127:0] d, input logic m);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = m ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = d[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({ov4, om4, cnt4, ov6, ov8} !== '0 || od4 !== '0 || od8 !== '0) begin
            bad++;
            $display("FAIL reset_state: ov4=%b om4=%b cnt4=%0d od4=%h ov6=%b ov8=%b, want all 0",
                     ov4, om4, cnt4, od4, ov6, ov8);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (ir4 !== 1'b1 || ir6 !== 1'b1 || ir8 !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: ir4=%b ir6=%b ir8=%b, want 1", ir4, ir6, ir8);
        end
    endtask

    task automatic test_fips(input logic mode, input logic [127:0] din,
                             input logic [127:0] dexp, input logic [3:0] cexp);
        @(negedge clk);
        iv4 = 1'b1; id4 = din; im4 = mode; or4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        total++;
        if (ov4 !== 1'b1 || od4 !== dexp || om4 !== mode) begin
            bad++;
            $display("FAIL fips_mode%0d: valid=%b data=%h mode=%b, want 1 %h %b",
                     mode, ov4, od4, om4, dexp, mode);
        end
        @(negedge clk);
        total++;
        if (cnt4 !== cexp || ov4 !== 1'b0) begin
            bad++;
            $display("FAIL fips_cnt%0d: cnt=%0d valid=%b, want %0d 0", mode, cnt4, ov4, cexp);
        end
    endtask

    task automatic test_nb8();
        logic [255:0] back;
        @(negedge clk);
        iv8 = 1'b1; id8 = IDX8; im8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        total++;
        if (ov8 !== 1'b1 || od8 !== IDX8_FWD || od8[255:224] !== 32'h00050e13 || om8 !== 1'b0)
        begin
            bad++;
            $display("FAIL nb8_fwd: valid=%b data=%h mode=%b, want 1 %h 0", ov8, od8, om8,
                     IDX8_FWD);
        end
        back = od8;
        id8 = back; im8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        total++;
        if (ov8 !== 1'b1 || od8 !== IDX8 || om8 !== 1'b1) begin
            bad++;
            $display("FAIL nb8_inv: valid=%b data=%h mode=%b, want 1 %h 1", ov8, od8, om8, IDX8);
        end
        @(negedge clk);
        total++;
        if (cnt8 !== 16'd2) begin
            bad++;
            $display("FAIL nb8_cnt: cnt=%0d, want 2", cnt8);
        end
    endtask

    task automatic test_nb6();
        logic [191:0] back;
        @(negedge clk);
        iv6 = 1'b1; id6 = IDX6; im6 = 1'b0; or6 = 1'b1;
        @(negedge clk);
        total++;
        if (ov6 !== 1'b1 || od6 !== IDX6_FWD || od6[191:160] !== 32'h00050a0f || om6 !== 1'b0)
        begin
            bad++;
            $display("FAIL nb6_fwd: valid=%b data=%h mode=%b, want 1 %h 0", ov6, od6, om6,
                     IDX6_FWD);
        end
        back = od6;
        id6 = back; im6 = 1'b1;
        @(negedge clk);
        iv6 = 1'b0;
        total++;
        if (ov6 !== 1'b1 || od6 !== IDX6 || om6 !== 1'b1) begin
            bad++;
            $display("FAIL nb6_inv: valid=%b data=%h mode=%b, want 1 %h 1", ov6, od6, om6, IDX6);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] src [4];
        logic [127:0] exp [4];
        logic         md  [4];
        int si = 0;
        int ei = 0;
        src[0] = FIPS_IN;  exp[0] = FIPS_OUT; md[0] = 1'b0;
        src[1] = FIPS_OUT; exp[1] = FIPS_IN;  md[1] = 1'b1;
        src[2] = IDX4;     exp[2] = IDX4_FWD; md[2] = 1'b0;
        src[3] = IDX4_FWD; exp[3] = IDX4;     md[3] = 1'b1;
        or4 = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (cyc == 4) or4 = 1'b1;
            iv4 = (si < 4);
            if (si < 4) begin
                id4 = src[si]; im4 = md[si];
            end
            #1;
            if (cyc <= 3) begin
                total++;
                if (ir4 !== (cyc < 2)) begin
                    bad++;
                    $display("FAIL bp_ready_c%0d: ready=%b, want %b", cyc, ir4, cyc < 2);
                end
            end
            if (cyc >= 1 && cyc <= 3) begin
                total++;
                if (ov4 !== 1'b1 || od4 !== exp[0] || om4 !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_hold_c%0d: valid=%b data=%h, want 1 %h", cyc, ov4, od4,
                             exp[0]);
                end
            end
            if (cyc >= 4 && cyc <= 7) begin
                total++;
                if (ov4 !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_gap_c%0d: valid=%b, want 1", cyc, ov4);
                end
            end
            if (ov4 && or4 && ei < 4) begin
                total++;
                if (od4 !== exp[ei] || om4 !== md[ei]) begin
                    bad++;
                    $display("FAIL bp_order%0d: data=%h mode=%b, want %h %b", ei, od4, om4,
                             exp[ei], md[ei]);
                end
                ei++;
            end
            if (iv4 && ir4) si++;
        end
        iv4 = 1'b0;
        total++;
        if (ei !== 4 || cnt4 !== 4'd6) begin
            bad++;
            $display("FAIL bp_count: delivered=%0d cnt=%0d, want 4 6", ei, cnt4);
        end
    endtask

    task automatic test_flush();
        or4 = 1'b0;
        @(negedge clk); iv4 = 1'b1; id4 = FIPS_IN; im4 = 1'b0;
        @(negedge clk); id4 = FIPS_OUT; im4 = 1'b1;
        @(negedge clk); id4 = IDX4; im4 = 1'b0; flush4 = 1'b1;
        #1;
        total++;
        if (ir4 !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready_low: ready=%b, want 0", ir4);
        end
        @(negedge clk); flush4 = 1'b0; iv4 = 1'b0;
        #1;
        total++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1 || cnt4 !== 4'd6) begin
            bad++;
            $display("FAIL flush_clear: valid=%b ready=%b cnt=%0d, want 0 1 6", ov4, ir4, cnt4);
        end
        or4 = 1'b1;
        @(negedge clk);
        total++;
        if (ov4 !== 1'b0) begin
            bad++;
            $display("FAIL flush_noaccept: valid=%b, want 0", ov4);
        end
        // A handshake in the flush cycle still counts.
        or4 = 1'b0; iv4 = 1'b1; id4 = IDX4; im4 = 1'b0;
        @(negedge clk); iv4 = 1'b0; flush4 = 1'b1; or4 = 1'b1;
        @(negedge clk); flush4 = 1'b0;
        total++;
        if (cnt4 !== 4'd7 || ov4 !== 1'b0) begin
            bad++;
            $display("FAIL flush_drain_cnt: cnt=%0d valid=%b, want 7 0", cnt4, ov4);
        end
    endtask

    task automatic test_reset_mid();
        or4 = 1'b0;
        @(negedge clk); iv4 = 1'b1; id4 = FIPS_OUT; im4 = 1'b1;
        @(negedge clk); iv4 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ov4 !== 1'b0 || od4 !== '0 || om4 !== 1'b0 || cnt4 !== 4'd0 || ir4 !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: valid=%b data=%h mode=%b cnt=%0d ready=%b, want 0 0 0 0 1",
                     ov4, od4, om4, cnt4, ir4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        or4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            iv4 = 1'b1; id4 = 128'(i); im4 = i[0];
        end
        @(negedge clk); iv4 = 1'b0;
        @(negedge clk);
        total++;
        if (cnt4 !== 4'd1 || ov4 !== 1'b0) begin
            bad++;
            $display("FAIL wrap: cnt=%0d valid=%b, want 1 0", cnt4, ov4);
        end
    endtask

    task automatic test_random();
        logic [127:0] q_data [$];
        logic         q_mode [$];
        int  sent = 0;
        int  got  = 0;
        int  cyc  = 0;
        bit  hold = 0;
        while (got < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                iv4 = (sent < 10000) && ($urandom_range(0, 3) != 0);
                id4 = {$urandom(), $urandom(), $urandom(), $urandom()};
                im4 = 1'($urandom_range(0, 1));
            end
            or4 = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (ov4 !== (q_data.size() != 0) || q_data.size() > 2) begin
                bad++;
                $display("FAIL rand_valid@%0d: valid=%b, want %b (occupancy %0d)", cyc, ov4,
                         q_data.size() != 0, q_data.size());
            end
            if (ov4 && or4 && q_data.size() != 0) begin
                total++;
                if (od4 !== q_data[0] || om4 !== q_mode[0]) begin
                    bad++;
                    $display("FAIL rand_beat%0d: data=%h mode=%b, want %h %b", got, od4, om4,
                             q_data[0], q_mode[0]);
                end
                void'(q_data.pop_front());
                void'(q_mode.pop_front());
                got++;
            end
            if (iv4 && ir4) begin
                q_data.push_back(ref4(id4, im4));
                q_mode.push_back(im4);
                sent++;
                hold = 0;
            end else begin
                hold = iv4;
            end
        end
        if (got < 10000) begin
            total++;
            bad++;
            $display("FAIL rand_timeout: delivered=%0d, want 10000", got);
        end
        @(negedge clk);
        iv4 = 1'b0; or4 = 1'b0;
        #1;
        total++;
        if (cnt4 !== 4'(1 + got)) begin
            bad++;
            $display("FAIL rand_cnt: cnt=%0d, want %0d", cnt4, 4'(1 + got));
        end
    endtask

    initial begin
        {flush4, iv4, im4, or4} = '0; id4 = '0;
        {flush6, iv6, im6, or6} = '0; id6 = '0;
        {flush8, iv8, im8, or8} = '0; id8 = '0;
        test_reset();
        test_fips(1'b0, FIPS_IN, FIPS_OUT, 4'd1);
        test_fips(1'b1, FIPS_OUT, FIPS_IN, 4'd2);
        test_nb8();
        test_nb6();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
